// File: rtl/per2axi_pkg.sv
// Shared definitions for the peripheral-to-AXI bridge: AXI response codes and
// the atomic-operation codes used by the request channel.
package per2axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [5:0] AMO_NONE = 6'h00;
    localparam logic [5:0] AMO_LR   = 6'h02;
    localparam logic [5:0] AMO_SC   = 6'h03;
    localparam logic [5:0] AMO_SWAP = 6'h01;
    localparam logic [5:0] AMO_ADD  = 6'h00 | 6'h20;
    localparam logic [5:0] AMO_XOR  = 6'h04;
    localparam logic [5:0] AMO_AND  = 6'h0C;
    localparam logic [5:0] AMO_OR   = 6'h08;
    localparam logic [5:0] AMO_MIN  = 6'h10;
    localparam logic [5:0] AMO_MAX  = 6'h14;
    localparam logic [5:0] AMO_MINU = 6'h18;
    localparam logic [5:0] AMO_MAXU = 6'h1C;

    // SC result word returned on a write response: 0 = success, 1 = failure.
    function automatic logic [31:0] sc_result(input logic [1:0] resp);
        return (resp == RESP_EXOKAY) ? 32'h0 : 32'h1;
    endfunction

endpackage

// File: rtl/per2axi_resp_arb.sv
// Two-input toggle-priority arbiter between AXI R and B channels.
// Handshake: a beat transfers on a cycle where valid and ready are both 1.
module per2axi_resp_arb (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_r_valid,
    input  logic i_b_valid,
    output logic o_r_ready,
    output logic o_b_ready,
    output logic o_sel_b,
    output logic o_prio
);

    logic r_prio;
    logic w_prio_next;
    logic w_conflict;

    assign w_conflict = i_r_valid & i_b_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prio <= 1'b0;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    // Priority only flips when both sides compete, so a lone requester never
    // steals the next turn from the other side.
    always_comb begin
        w_prio_next = r_prio;
        if (w_conflict) begin
            w_prio_next = ~r_prio;
        end
    end

    always_comb begin
        o_r_ready = 1'b0;
        o_b_ready = 1'b0;
        if (!i_rst) begin
            o_r_ready = i_r_valid & (~i_b_valid | ~r_prio);
            o_b_ready = i_b_valid & (~i_r_valid |  r_prio);
        end
    end

    assign o_sel_b = o_b_ready;
    assign o_prio  = r_prio;

endmodule

// File: rtl/per2axi_res_channel.sv
// Response half of the peripheral-to-AXI bridge: merges AXI R and B beats into
// a single registered peripheral response stream with per-ID lane selection.
module per2axi_res_channel
    import per2axi_pkg::*;
#(
    parameter int PER_ID_WIDTH   = 5,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,
    input  logic                      axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
    input  logic [1:0]                axi_master_r_resp_i,
    input  logic                      axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
    output logic                      axi_master_r_ready_o,
    input  logic                      axi_master_b_valid_i,
    input  logic [1:0]                axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
    output logic                      axi_master_b_ready_o,
    input  logic                      trans_req_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i
);

    localparam int DEPTH = 2 ** AXI_ID_WIDTH;

    logic [DEPTH-1:0]        r_lane;
    logic                    w_r_hs;
    logic                    w_b_hs;
    logic                    w_sel_b;
    logic                    w_arb_prio;
    logic [AXI_ID_WIDTH-1:0] w_sel_id;
    logic [PER_ID_WIDTH-1:0] w_sel_id_oh;
    logic [31:0]             w_r_word;
    logic                    w_unused_bits;

    per2axi_resp_arb u_arb (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_r_valid (axi_master_r_valid_i),
        .i_b_valid (axi_master_b_valid_i),
        .o_r_ready (axi_master_r_ready_o),
        .o_b_ready (axi_master_b_ready_o),
        .o_sel_b   (w_sel_b),
        .o_prio    (w_arb_prio)
    );

    assign w_r_hs = axi_master_r_valid_i & axi_master_r_ready_o;
    assign w_b_hs = axi_master_b_valid_i & axi_master_b_ready_o;

    // Lane bit is address bit 2: which 32-bit half of the 64-bit beat is wanted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lane <= '0;
        end else if (trans_req_i) begin
            r_lane[trans_id_i] <= trans_add_i[2];
        end
    end

    assign w_r_word = r_lane[axi_master_r_id_i] ? axi_master_r_data_i[63:32]
                                                : axi_master_r_data_i[31:0];
    assign w_sel_id = w_sel_b ? axi_master_b_id_i : axi_master_r_id_i;

    always_comb begin
        w_sel_id_oh = '0;
        for (int i = 0; i < PER_ID_WIDTH; i++) begin
            if (32'(w_sel_id) == i) begin
                w_sel_id_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            per_slave_r_valid_o <= 1'b0;
            per_slave_r_opc_o   <= 1'b0;
            per_slave_r_id_o    <= '0;
            per_slave_r_rdata_o <= '0;
        end else if (w_r_hs) begin
            per_slave_r_valid_o <= 1'b1;
            per_slave_r_opc_o   <= axi_master_r_resp_i[1];
            per_slave_r_id_o    <= w_sel_id_oh;
            per_slave_r_rdata_o <= w_r_word;
        end else if (w_b_hs) begin
            per_slave_r_valid_o <= 1'b1;
            per_slave_r_opc_o   <= axi_master_b_resp_i[1];
            per_slave_r_id_o    <= w_sel_id_oh;
            per_slave_r_rdata_o <= sc_result(axi_master_b_resp_i);
        end else begin
            per_slave_r_valid_o <= 1'b0;
        end
    end

    assign w_unused_bits = ^{axi_master_r_last_i, axi_master_r_user_i,
                             axi_master_b_user_i, trans_add_i, w_arb_prio};

    // An AXI ID with no matching one-hot bit means the bridge is misconfigured.
    a_id_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        (w_r_hs | w_b_hs) |-> (32'(w_sel_id) < PER_ID_WIDTH));

endmodule

// File: tb/tb_per2axi_res_channel.sv
// Directed bench for per2axi_res_channel: reset, lane select, SC results,
// R/B collision fairness and same-cycle table write/read ordering.
module tb_per2axi_res_channel;

  logic        clk;
  logic        rst;
  logic        per_valid;
  logic        per_opc;
  logic [4:0]  per_id;
  logic [31:0] per_rdata;
  logic        r_valid;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [2:0]  r_id;
  logic [5:0]  r_user;
  logic        r_ready;
  logic        b_valid;
  logic [1:0]  b_resp;
  logic [2:0]  b_id;
  logic [5:0]  b_user;
  logic        b_ready;
  logic        trans_req;
  logic [2:0]  trans_id;
  logic [31:0] trans_add;

  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] exp_q[$];

  per2axi_res_channel dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .per_slave_r_valid_o  (per_valid),
    .per_slave_r_opc_o    (per_opc),
    .per_slave_r_id_o     (per_id),
    .per_slave_r_rdata_o  (per_rdata),
    .axi_master_r_valid_i (r_valid),
    .axi_master_r_data_i  (r_data),
    .axi_master_r_resp_i  (r_resp),
    .axi_master_r_last_i  (r_last),
    .axi_master_r_id_i    (r_id),
    .axi_master_r_user_i  (r_user),
    .axi_master_r_ready_o (r_ready),
    .axi_master_b_valid_i (b_valid),
    .axi_master_b_resp_i  (b_resp),
    .axi_master_b_id_i    (b_id),
    .axi_master_b_user_i  (b_user),
    .axi_master_b_ready_o (b_ready),
    .trans_req_i          (trans_req),
    .trans_id_i           (trans_id),
    .trans_add_i          (trans_add)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] rdata,
                            input logic opc, input logic [4:0] id);
    check({tag, "_valid"}, 32'(per_valid), 32'd1);
    check({tag, "_rdata"}, per_rdata, rdata);
    check({tag, "_opc"},   32'(per_opc), 32'(opc));
    check({tag, "_id"},    32'(per_id), 32'(id));
  endtask

  // driver tasks
  task automatic issue(input logic [2:0] id, input logic [31:0] add);
    trans_req = 1'b1;
    trans_id  = id;
    trans_add = add;
    step();
    trans_req = 1'b0;
  endtask

  task automatic send_r(input string tag, input logic [2:0] id, input logic [63:0] data,
                        input logic [1:0] resp, input logic [31:0] exp_rdata,
                        input logic exp_opc, input logic [4:0] exp_id);
    r_valid = 1'b1;
    r_id    = id;
    r_data  = data;
    r_resp  = resp;
    #1;
    check({tag, "_r_ready"}, 32'(r_ready), 32'd1);
    check({tag, "_b_ready"}, 32'(b_ready), 32'd0);
    @(posedge clk);
    #1;
    r_valid = 1'b0;
    trans_req = 1'b0;
    check_resp(tag, exp_rdata, exp_opc, exp_id);
  endtask

  task automatic send_b(input string tag, input logic [2:0] id, input logic [1:0] resp,
                        input logic [31:0] exp_rdata, input logic exp_opc,
                        input logic [4:0] exp_id);
    b_valid = 1'b1;
    b_id    = id;
    b_resp  = resp;
    #1;
    check({tag, "_b_ready"}, 32'(b_ready), 32'd1);
    check({tag, "_r_ready"}, 32'(r_ready), 32'd0);
    step();
    b_valid = 1'b0;
    check_resp(tag, exp_rdata, exp_opc, exp_id);
  endtask

  initial begin
    rst = 1'b1;
    r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b1; r_id = '0; r_user = '0;
    b_valid = 1'b0; b_resp = 2'b00; b_id = '0; b_user = '0;
    trans_req = 1'b0; trans_id = '0; trans_add = '0;

    // reset held with R pending
    r_valid = 1'b1;
    r_id    = 3'd2;
    r_data  = 64'hAAAA_BBBB_CCCC_DDDD;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_r_ready", 32'(r_ready), 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd0);
      check("rst_valid",   32'(per_valid), 32'd0);
    end
    check("rst_rdata", per_rdata, 32'h0);
    check("rst_opc",   32'(per_opc), 32'd0);
    check("rst_id",    32'(per_id), 32'd0);
    rst = 1'b0;
    send_r("post_rst", 3'd2, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 32'hCCCC_DDDD, 1'b0, 5'b00100);

    // idle cycle: valid drops, payload holds
    step();
    check("idle_valid", 32'(per_valid), 32'd0);
    check("idle_hold",  per_rdata, 32'hCCCC_DDDD);

    // lane select
    issue(3'd1, 32'h1000_0004);
    send_r("lane_hi", 3'd1, 64'h1122_3344_5566_7788, 2'b00, 32'h1122_3344, 1'b0, 5'b00010);
    issue(3'd1, 32'h1000_0000);
    send_r("lane_lo", 3'd1, 64'h1122_3344_5566_7788, 2'b00, 32'h5566_7788, 1'b0, 5'b00010);

    // write / SC responses
    send_b("b_exokay", 3'd0, 2'b01, 32'h0, 1'b0, 5'b00001);
    send_b("b_okay",   3'd0, 2'b00, 32'h1, 1'b0, 5'b00001);
    send_b("b_slverr", 3'd2, 2'b10, 32'h1, 1'b1, 5'b00100);

    // collision: priority starts at R, alternates R, B, R, B
    r_valid = 1'b1; r_id = 3'd2; r_data = 64'h0BAD_F00D_1234_5678; r_resp = 2'b00;
    b_valid = 1'b1; b_id = 3'd3; b_resp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back({5'b00100, 32'h1234_5678});
      else            exp_q.push_back({5'b01000, 32'h0000_0001});
    end
    for (int i = 0; i < 4; i++) begin
      logic [36:0] e;
      #1;
      check("col_r_ready", 32'(r_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("col_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("col_valid", 32'(per_valid), 32'd1);
      check("col_id",    32'(per_id), 32'(e[36:32]));
      check("col_rdata", per_rdata, e[31:0]);
    end
    r_valid = 1'b0;
    b_valid = 1'b0;
    step();
    check("col_done_valid", 32'(per_valid), 32'd0);

    // same-cycle table write and R lookup: old lane wins
    trans_req = 1'b1; trans_id = 3'd3; trans_add = 32'h0000_0004;
    send_r("same_cyc", 3'd3, 64'hDEAD_BEEF_0123_4567, 2'b00, 32'h0123_4567, 1'b0, 5'b01000);
    send_r("after_wr", 3'd3, 64'hDEAD_BEEF_0123_4567, 2'b00, 32'hDEAD_BEEF, 1'b0, 5'b01000);

    // error read
    send_r("decerr", 3'd4, 64'h5555_6666_7777_8888, 2'b11, 32'h7777_8888, 1'b1, 5'b10000);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
